ctrl_unit: RTL and testbench

//  Instruction sequencer of the 8-bit teaching CPU; directly downstream of the instruction register.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/ctrl_wait_timer.sv | 29 ++
 rtl/ctrl_unit.sv | 156 +++++++++++++++
 tb/tb_ctrl_unit.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit teaching CPU control path.
// Opcode, FSM state and ALU op encodings plus IR field helpers.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_JMP = 4'h5,
    OP_JZ  = 4'h6,
    OP_LDI = 4'h7,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F_ADDR,
    S_F_WAIT,
    S_DECODE,
    S_X_WAIT,
    S_HALT
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_IMM  = 2'b11
  } alu_op_e;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int OPND_HI = 3;
  localparam int OPND_LO = 0;

  function automatic opcode_e opc(input logic [7:0] ir);
    return opcode_e'(ir[OPC_HI:OPC_LO]);
  endfunction

  function automatic logic [3:0] operand(input logic [7:0] ir);
    return ir[OPND_HI:OPND_LO];
  endfunction

  // ALU selection while the operand read is in flight
  function automatic alu_op_e mem_alu(input opcode_e op);
    alu_op_e a;
    a = ALU_PASS;
    if (op == OP_ADD) a = ALU_ADD;
    if (op == OP_SUB) a = ALU_SUB;
    return a;
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory wait counter: clears while not waiting, counts stalled cycles.
// Ports: clk, reset, clear, enable in; expired out (count == WAIT_MAX).
module ctrl_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(WAIT_MAX + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(WAIT_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/ctrl_unit.sv
// Fetch/decode/execute sequencer with memory timeout and retire counter.
// Ports: clk, reset, start, ir_data, zero_flag, mem_ready in; strobes, status out.
module ctrl_unit
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       ir_data,
  input  logic             zero_flag,
  input  logic             mem_ready,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_load,
  output logic             mar_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             acc_load,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             fault,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  ctrl_state_e state, next;
  opcode_e     op;
  alu_op_e     alu;
  logic        wait_st;
  logic        expired;
  logic        timeout;
  logic        fetched;
  logic        unused_operand;

  assign op      = opc(ir_data);
  assign wait_st = (state == S_F_WAIT) || (state == S_X_WAIT);
  // mem_ready in the expiring cycle still completes normally
  assign timeout = wait_st && !mem_ready && expired;
  assign fetched = (state == S_F_WAIT) && mem_ready;
  assign alu_op  = alu;

  // operand field is consumed by the datapath, not here
  assign unused_operand = ^operand(ir_data);

  ctrl_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!wait_st),
    .enable (wait_st && !mem_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      if (timeout) fault <= 1'b1;
      if (fetched) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:   if (start) next = S_F_ADDR;
      S_F_ADDR: next = S_F_WAIT;
      S_F_WAIT: begin
        if (mem_ready)    next = S_DECODE;
        else if (timeout) next = S_HALT;
      end
      S_DECODE: begin
        unique case (op)
          OP_LDA, OP_ADD,
          OP_SUB, OP_STA: next = S_X_WAIT;
          OP_HLT:         next = S_HALT;
          default:        next = S_F_ADDR;
        endcase
      end
      S_X_WAIT: begin
        if (mem_ready)    next = S_F_ADDR;
        else if (timeout) next = S_HALT;
      end
      S_HALT:   next = S_HALT;
      default:  next = S_IDLE;
    endcase
  end

  always_comb begin
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    mar_sel    = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    acc_load   = 1'b0;
    alu        = ALU_PASS;
    illegal_op = 1'b0;
    halted     = (state == S_HALT);
    unique case (state)
      S_F_ADDR: mar_load = 1'b1;
      S_F_WAIT: begin
        if (!timeout) begin
          mem_rd  = 1'b1;
          ir_load = mem_ready;
          pc_inc  = mem_ready;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_NOP, OP_HLT: ;
          OP_LDI: begin
            acc_load = 1'b1;
            alu      = ALU_IMM;
          end
          OP_JMP: pc_load = 1'b1;
          OP_JZ:  pc_load = zero_flag;
          OP_LDA, OP_ADD,
          OP_SUB, OP_STA: begin
            mar_load = 1'b1;
            mar_sel  = 1'b1;
          end
          default: illegal_op = 1'b1;
        endcase
      end
      S_X_WAIT: begin
        if (!timeout) begin
          if (op == OP_STA) begin
            mem_wr = 1'b1;
          end else begin
            mem_rd   = 1'b1;
            alu      = mem_alu(op);
            acc_load = mem_ready;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: default instance A, small instance B.
// B uses WAIT_MAX=3, CNT_W=4 for timeout and counter-wrap scenarios.
module tb_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ir_data = 8'h00;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;

  logic        a_ir_load, a_pc_inc, a_pc_load, a_mar_load, a_mar_sel;
  logic        a_mem_rd, a_mem_wr, a_acc_load, a_halted, a_fault;
  logic        a_illegal_op;
  logic [1:0]  a_alu_op;
  logic [15:0] a_instr_count;

  logic        b_ir_load, b_pc_inc, b_pc_load, b_mar_load, b_mar_sel;
  logic        b_mem_rd, b_mem_wr, b_acc_load, b_halted, b_fault;
  logic        b_illegal_op;
  logic [1:0]  b_alu_op;
  logic [3:0]  b_instr_count;

  logic [13:0] a_outs;
  logic [13:0] b_outs;

  int checks = 0;
  int errors = 0;

  assign a_outs = {a_ir_load, a_pc_inc, a_pc_load, a_mar_load,
                   a_mar_sel, a_mem_rd, a_mem_wr, a_acc_load,
                   a_alu_op, a_halted, a_fault, a_illegal_op};
  assign b_outs = {b_ir_load, b_pc_inc, b_pc_load, b_mar_load,
                   b_mar_sel, b_mem_rd, b_mem_wr, b_acc_load,
                   b_alu_op, b_halted, b_fault, b_illegal_op};

  always #5 clk = ~clk;

  ctrl_unit dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ir_data    (ir_data),
    .zero_flag  (zero_flag),
    .mem_ready  (mem_ready),
    .ir_load    (a_ir_load),
    .pc_inc     (a_pc_inc),
    .pc_load    (a_pc_load),
    .mar_load   (a_mar_load),
    .mar_sel    (a_mar_sel),
    .mem_rd     (a_mem_rd),
    .mem_wr     (a_mem_wr),
    .acc_load   (a_acc_load),
    .alu_op     (a_alu_op),
    .halted     (a_halted),
    .fault      (a_fault),
    .illegal_op (a_illegal_op),
    .instr_count(a_instr_count)
  );

  ctrl_unit #(
    .WAIT_MAX(3),
    .CNT_W   (4)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ir_data    (ir_data),
    .zero_flag  (zero_flag),
    .mem_ready  (mem_ready),
    .ir_load    (b_ir_load),
    .pc_inc     (b_pc_inc),
    .pc_load    (b_pc_load),
    .mar_load   (b_mar_load),
    .mar_sel    (b_mar_sel),
    .mem_rd     (b_mem_rd),
    .mem_wr     (b_mem_wr),
    .acc_load   (b_acc_load),
    .alu_op     (b_alu_op),
    .halted     (b_halted),
    .fault      (b_fault),
    .illegal_op (b_illegal_op),
    .instr_count(b_instr_count)
  );

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    start     = 1'b0;
    mem_ready = 1'b0;
    zero_flag = 1'b0;
    #1;
    tick();
    reset = 1'b0;
  endtask

  // from IDLE: pulse start, return in the F_ADDR cycle
  task automatic kick;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // from F_ADDR: fetch instr with immediate mem_ready, return in DECODE
  task automatic fetch(input logic [7:0] instr);
    mem_ready = 1'b1;
    tick();
    ir_data = instr;
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1;
    checks++;
    if (a_outs !== 14'h0 || a_instr_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_state outs=%h cnt=%0d exp 0 0", a_outs, a_instr_count);
    end
    do_reset();
    ir_data = 8'h00;
    kick();
    fetch(8'h00);
    #1;
    checks++;
    if (a_instr_count !== 16'd1) begin
      errors++;
      $display("FAIL rst_precount got %0d exp 1", a_instr_count);
    end
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if (a_mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL rst_fwait_rd got %b exp 1", a_mem_rd);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (a_outs !== 14'h0 || a_instr_count !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid outs=%h cnt=%0d exp 0 0", a_outs, a_instr_count);
    end
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (a_outs !== 14'h0) begin
        errors++;
        $display("FAIL rst_idle%0d outs=%h exp 0", i, a_outs);
      end
      tick();
    end
    kick();
    #1;
    checks++;
    if (a_mar_load !== 1'b1 || a_mar_sel !== 1'b0) begin
      errors++;
      $display("FAIL rst_restart mar=%b sel=%b exp 1 0", a_mar_load, a_mar_sel);
    end
  endtask

  task automatic test_ldi;
    do_reset();
    ir_data = 8'h75;
    mem_ready = 1'b1;
    kick();
    #1;
    checks++;
    if (a_ir_load !== 1'b0 || a_mar_load !== 1'b1) begin
      errors++;
      $display("FAIL ldi_c1 irl=%b mar=%b exp 0 1", a_ir_load, a_mar_load);
    end
    tick();
    #1;
    checks++;
    if (a_ir_load !== 1'b1 || a_pc_inc !== 1'b1 || a_mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL ldi_c2 irl=%b inc=%b rd=%b exp 1 1 1", a_ir_load, a_pc_inc, a_mem_rd);
    end
    tick();
    #1;
    checks++;
    if (a_acc_load !== 1'b1 || a_alu_op !== 2'b11 || a_instr_count !== 16'd1) begin
      errors++;
      $display("FAIL ldi_c3 acc=%b alu=%b cnt=%0d exp 1 11 1", a_acc_load, a_alu_op, a_instr_count);
    end
    tick();
    #1;
    checks++;
    if (a_mar_load !== 1'b1 || a_acc_load !== 1'b0) begin
      errors++;
      $display("FAIL ldi_c4 mar=%b acc=%b exp 1 0", a_mar_load, a_acc_load);
    end
  endtask

  task automatic test_add_wait;
    int rd_cnt;
    int acc_cnt;
    rd_cnt  = 0;
    acc_cnt = 0;
    do_reset();
    kick();
    fetch(8'h23);
    #1;
    checks++;
    if (a_mar_load !== 1'b1 || a_mar_sel !== 1'b1 || a_acc_load !== 1'b0) begin
      errors++;
      $display("FAIL add_dec mar=%b sel=%b acc=%b exp 1 1 0", a_mar_load, a_mar_sel, a_acc_load);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i == 4);
      #1;
      rd_cnt  += a_mem_rd;
      acc_cnt += a_acc_load;
      checks++;
      if (a_alu_op !== 2'b01) begin
        errors++;
        $display("FAIL add_alu%0d got %b exp 01", i, a_alu_op);
      end
      tick();
    end
    checks++;
    if (rd_cnt != 5 || acc_cnt != 1) begin
      errors++;
      $display("FAIL add_counts rd=%0d acc=%0d exp 5 1", rd_cnt, acc_cnt);
    end
    #1;
    checks++;
    if (a_mem_rd !== 1'b0 || a_mar_load !== 1'b1 || a_mar_sel !== 1'b0) begin
      errors++;
      $display("FAIL add_next rd=%b mar=%b sel=%b exp 0 1 0", a_mem_rd, a_mar_load, a_mar_sel);
    end
  endtask

  task automatic test_jz_sta;
    do_reset();
    kick();
    zero_flag = 1'b0;
    fetch(8'h6A);
    #1;
    checks++;
    if (a_pc_load !== 1'b0 || a_illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL jz0 pcl=%b ill=%b exp 0 0", a_pc_load, a_illegal_op);
    end
    tick();
    zero_flag = 1'b1;
    fetch(8'h6A);
    #1;
    checks++;
    if (a_pc_load !== 1'b1) begin
      errors++;
      $display("FAIL jz1 pcl=%b exp 1", a_pc_load);
    end
    tick();
    fetch(8'h4C);
    #1;
    checks++;
    if (a_mar_sel !== 1'b1 || a_mar_load !== 1'b1) begin
      errors++;
      $display("FAIL sta_dec sel=%b mar=%b exp 1 1", a_mar_sel, a_mar_load);
    end
    tick();
    #1;
    checks++;
    if (a_mem_wr !== 1'b1 || a_mem_rd !== 1'b0 || a_acc_load !== 1'b0) begin
      errors++;
      $display("FAIL sta_x wr=%b rd=%b acc=%b exp 1 0 0", a_mem_wr, a_mem_rd, a_acc_load);
    end
    tick();
    #1;
    checks++;
    if (a_mem_wr !== 1'b0 || a_mar_load !== 1'b1) begin
      errors++;
      $display("FAIL sta_next wr=%b mar=%b exp 0 1", a_mem_wr, a_mar_load);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    ir_data = 8'h00;
    kick();
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b_mem_rd !== 1'b1 || b_halted !== 1'b0 || b_fault !== 1'b0) begin
        errors++;
        $display("FAIL to_wait%0d rd=%b h=%b f=%b exp 1 0 0", i, b_mem_rd, b_halted, b_fault);
      end
      tick();
    end
    #1;
    checks++;
    if (b_outs !== 14'h0 || a_mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL to_expire b_outs=%h a_rd=%b exp 0 1", b_outs, a_mem_rd);
    end
    tick();
    #1;
    checks++;
    if (b_halted !== 1'b1 || b_fault !== 1'b1) begin
      errors++;
      $display("FAIL to_halt h=%b f=%b exp 1 1", b_halted, b_fault);
    end
    start = 1'b1;
    mem_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1;
    checks++;
    if (b_outs !== 14'b00000000000110) begin
      errors++;
      $display("FAIL to_stay outs=%b exp 00000000000110", b_outs);
    end
  endtask

  task automatic test_illegal_wrap;
    do_reset();
    kick();
    fetch(8'hB0);
    #1;
    checks++;
    if (b_illegal_op !== 1'b1 || a_illegal_op !== 1'b1 || b_instr_count !== 4'd1) begin
      errors++;
      $display("FAIL ill_dec b=%b a=%b cnt=%0d exp 1 1 1", b_illegal_op, a_illegal_op, b_instr_count);
    end
    tick();
    #1;
    checks++;
    if (b_illegal_op !== 1'b0 || b_mar_load !== 1'b1 || b_mar_sel !== 1'b0) begin
      errors++;
      $display("FAIL ill_refetch ill=%b mar=%b sel=%b exp 0 1 0", b_illegal_op, b_mar_load, b_mar_sel);
    end
    for (int n = 2; n <= 16; n++) begin
      fetch(8'h00);
      #1;
      if (n == 15) begin
        checks++;
        if (b_instr_count !== 4'd15) begin
          errors++;
          $display("FAIL wrap_pre got %0d exp 15", b_instr_count);
        end
      end
      tick();
    end
    checks++;
    if (b_instr_count !== 4'd0 || a_instr_count !== 16'd16) begin
      errors++;
      $display("FAIL wrap b=%0d a=%0d exp 0 16", b_instr_count, a_instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_add_wait();
    test_jz_sta();
    test_timeout();
    test_illegal_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
